// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns PC and IR, addresses a 1-cycle-latency ROM and hands
// instructions to execute over a valid/done handshake. Optional macro: FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
   parameter logic [9:0] RESET_PC    = 10'd0,
   parameter logic [3:0] HALT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [9:0]  rom_addr,
   input  logic [9:0]  rom_data,
   output logic [9:0]  instr,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        branch,
   input  logic [9:0]  branch_addr,
   input  logic        jump,
   input  logic [9:0]  jump_target,
   output logic [9:0]  pc,
`ifdef FETCH_SEQ_PERF_EN
   output logic [15:0] retired,
`endif
   output logic        halted
);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StLatch,
      StExec,
      StHalt
   } state_e;

   state_e      state_q, state_d;
   logic [9:0]  pc_q, pc_d;
   logic [9:0]  ir_q, ir_d;
   logic        instr_valid_q, instr_valid_d;
   logic        halted_q, halted_d;
   logic        retire;

   assign retire = (state_q == StExec) && exec_done;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StAddr;
         StAddr:  state_d = StLatch;
         StLatch: begin
            ir_d    = rom_data;
            state_d = (rom_data[9:6] == HALT_OPCODE) ? StHalt : StExec;
         end
         StExec: begin
            if (exec_done) begin
               state_d = StAddr;
               if (jump)        pc_d = jump_target;
               else if (branch) pc_d = branch_addr;
               else             pc_d = pc_q + 10'd1;
            end
         end
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
      // Outputs are registered from the next state so they line up with state_q.
      instr_valid_d = (state_d == StExec);
      halted_d      = (state_d == StHalt);
   end

`ifdef FETCH_SEQ_PERF_EN
   logic [15:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if (retire) retired_d = retired_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) retired_q <= 16'd0;
      else       retired_q <= retired_d;
   end

   assign retired = retired_q;
`else
   logic unused_retire;
   assign unused_retire = retire;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         pc_q          <= RESET_PC;
         ir_q          <= 10'd0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ir_q          <= ir_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
      end
   end

   assign rom_addr    = pc_q;
   assign pc          = pc_q;
   assign instr       = ir_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: transaction-level PC/IR model over a registered ROM.
// Build with FETCH_SEQ_PERF_EN defined to also check the retired counter.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, exec_done, branch, jump;
   logic [9:0]  rom_addr, rom_data, instr, pc, branch_addr, jump_target;
   logic        instr_valid, halted;
`ifdef FETCH_SEQ_PERF_EN
   logic [15:0] retired;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   logic [9:0]  rom_mem [1024];
   logic [9:0]  mpc;
   int unsigned m_retired;

   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

   fetch_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .exec_done   (exec_done),
      .branch      (branch),
      .branch_addr (branch_addr),
      .jump        (jump),
      .jump_target (jump_target),
      .pc          (pc),
`ifdef FETCH_SEQ_PERF_EN
      .retired     (retired),
`endif
      .halted      (halted)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start       = 1'b0;
      exec_done   = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      branch_addr = 10'd0;
      jump_target = 10'd0;
   endtask

   // Random values on inputs that the current state must ignore.
   task automatic noise();
      start       = 1'($urandom);
      exec_done   = 1'($urandom);
      branch      = 1'($urandom);
      jump        = 1'($urandom);
      branch_addr = 10'($urandom);
      jump_target = 10'($urandom);
   endtask

   task automatic check_retired();
`ifdef FETCH_SEQ_PERF_EN
      check_eq("retired", 32'(retired), m_retired & 32'hFFFF);
`endif
   endtask

   task automatic check_idle_state(input string tag);
      check_eq({tag, "_pc"}, 32'(pc), 32'd0);
      check_eq({tag, "_instr"}, 32'(instr), 32'd0);
      check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
      check_eq({tag, "_halted"}, 32'(halted), 32'd0);
      check_retired();
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset     = 1'b0;
      mpc       = 10'd0;
      m_retired = 0;
      check_idle_state("reset");
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Called right after a start or retire edge; instruction must be valid two edges later.
   task automatic wait_valid();
      int waited = 0;
      while (!instr_valid && waited < 6) begin
         noise();
         step();
         waited++;
      end
      idle_inputs();
      check_eq("fetch_latency", waited, 32'd2);
      check_eq("valid_seen", 32'(instr_valid), 32'd1);
      check_eq("instr", 32'(instr), 32'(rom_mem[mpc]));
      check_eq("pc", 32'(pc), 32'(mpc));
      check_eq("rom_addr", 32'(rom_addr), 32'(mpc));
   endtask

   task automatic retire_one(input int stall, input logic j, input logic [9:0] jt,
                             input logic b, input logic [9:0] ba);
      logic [9:0] ir_seen;
      wait_valid();
      ir_seen = instr;
      for (int i = 0; i < stall; i++) begin
         exec_done   = 1'b0;
         branch      = 1'($urandom);
         jump        = 1'($urandom);
         branch_addr = 10'($urandom);
         jump_target = 10'($urandom);
         step();
         check_eq("stall_valid", 32'(instr_valid), 32'd1);
         check_eq("stall_pc", 32'(pc), 32'(mpc));
         check_eq("stall_instr", 32'(instr), 32'(ir_seen));
         check_retired();
      end
      exec_done   = 1'b1;
      jump        = j;
      jump_target = jt;
      branch      = b;
      branch_addr = ba;
      step();
      idle_inputs();
      if (j)      mpc = jt;
      else if (b) mpc = ba;
      else        mpc = 10'((32'(mpc) + 1) % 1024);
      m_retired++;
      check_eq("post_retire_valid", 32'(instr_valid), 32'd0);
      check_eq("next_pc", 32'(pc), 32'(mpc));
      check_retired();
   endtask

   task automatic expect_halt();
      logic [9:0] hpc;
      hpc = mpc;
      noise();
      step();
      check_eq("halt_latch_valid", 32'(instr_valid), 32'd0);
      check_eq("halt_latch_halted", 32'(halted), 32'd0);
      noise();
      step();
      idle_inputs();
      check_eq("halted", 32'(halted), 32'd1);
      check_eq("halt_valid", 32'(instr_valid), 32'd0);
      check_eq("halt_pc", 32'(pc), 32'(hpc));
      check_eq("halt_instr", 32'(instr), 32'(rom_mem[hpc]));
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exec_done = 1'($urandom);
         step();
         check_eq("halt_stays", 32'(halted), 32'd1);
         check_eq("halt_no_valid", 32'(instr_valid), 32'd0);
         check_eq("halt_pc_stable", 32'(pc), 32'(hpc));
         check_retired();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         logic [9:0] v;
         v = 10'($urandom);
         if (v[9:6] == 4'hF) v[9:6] = 4'h7;
         rom_mem[i] = v;
      end
      rom_mem[0] = 10'h001;
      rom_mem[1] = 10'h002;
      rom_mem[2] = 10'h003;

      // Sequential fetch with exec_done in the first EXEC cycle.
      do_reset();
      pulse_start();
      for (int i = 0; i < 3; i++) retire_one(0, 1'b0, 10'd0, 1'b0, 10'd0);
      check_eq("seq_pc", 32'(pc), 32'd3);

      // Branch at PC=5, then sequential from the target.
      retire_one(0, 1'b0, 10'd0, 1'b0, 10'd0);
      retire_one(1, 1'b0, 10'd0, 1'b0, 10'd0);
      retire_one(0, 1'b0, 10'd0, 1'b1, 10'd100);
      check_eq("branch_rom_addr", 32'(rom_addr), 32'd100);
      retire_one(0, 1'b0, 10'd0, 1'b0, 10'd0);
      check_eq("after_branch_pc", 32'(pc), 32'd101);

      // Jump beats branch.
      retire_one(0, 1'b1, 10'd500, 1'b1, 10'd100);
      check_eq("jump_prio_pc", 32'(pc), 32'd500);

      // Long stall.
      retire_one(10, 1'b0, 10'd0, 1'b0, 10'd0);

      // Random traffic.
      for (int n = 0; n < 40; n++) begin
         retire_one(int'($urandom_range(3, 0)), ($urandom_range(7, 0) == 0), 10'($urandom),
                    ($urandom_range(3, 0) == 0), 10'($urandom));
      end

      // Wrap from 1023 into a halt instruction at address 0.
      retire_one(0, 1'b1, 10'd1023, 1'b0, 10'd0);
      rom_mem[0] = 10'b1111000000;
      retire_one(0, 1'b0, 10'd0, 1'b0, 10'd0);
      check_eq("wrap_pc", 32'(pc), 32'd0);
      expect_halt();

      // Reset coinciding with a retirement aborts it.
      rom_mem[0] = 10'h001;
      do_reset();
      pulse_start();
      retire_one(0, 1'b0, 10'd0, 1'b0, 10'd0);
      retire_one(2, 1'b0, 10'd0, 1'b0, 10'd0);
      wait_valid();
      reset       = 1'b1;
      exec_done   = 1'b1;
      jump        = 1'b1;
      jump_target = 10'd77;
      step();
      idle_inputs();
      reset     = 1'b0;
      mpc       = 10'd0;
      m_retired = 0;
      check_idle_state("mid_exec_reset");
      step();
      check_idle_state("idle_hold");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle controller that sequences the 10-bit fetch datapath. It owns the PC register and the instruction register (IR), and addresses the synchronous instruction ROM. It hands each instruction to the execute stage over a valid/done handshake and applies branch/jump redirects on retirement. It sits between the instruction ROM and the decode/execute logic and replaces free-running PC increment with controlled, stallable fetch.

## Interface
- `RESET_PC`, 10'd0: PC value loaded by reset.
- `HALT_OPCODE`, 4'hF: value of `instr[9:6]` that halts the sequencer.

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: leave IDLE and begin fetching at the current PC.
- `rom_addr` out 10: ROM address; always equals `pc`.
- `rom_data` in 10: ROM read data, valid the cycle after `rom_addr` is presented (registered ROM, 1-cycle latency).
- `instr` out 10: IR contents.
- `instr_valid` out 1: IR holds an instruction awaiting execution; high only in EXEC.
- `exec_done` in 1: execute stage retires the current instruction; sampled only in EXEC.
- `branch` in 1, `branch_addr` in 10: redirect request, sampled with `exec_done`.
- `jump` in 1, `jump_target` in 10: redirect request, sampled with `exec_done`; has priority over `branch`.
- `pc` out 10: current PC.
- `halted` out 1: high in HALT.
- `retired` out 16: retired-instruction count (only with `FETCH_SEQ_PERF_EN`).

## Operation
- States: IDLE, ADDR, LATCH, EXEC, HALT. Encoding is implementer's choice.
- IDLE: `start`=1 goes to ADDR; otherwise stay.
- ADDR: `rom_addr`=`pc` is presented and the ROM registers it. Next state is LATCH unconditionally.
- LATCH: `rom_data` is valid and IR <= `rom_data`.
  - If `rom_data[9:6]`==`HALT_OPCODE`, go to HALT with PC unchanged.
  - Otherwise go to EXEC.
- EXEC: `instr_valid`=1. Stay while `exec_done`=0. When `exec_done`=1, go to ADDR and update PC:
  - `jump`=1: PC <= `jump_target`.
  - else `branch`=1: PC <= `branch_addr`.
  - else PC <= PC+1, modulo 1024 (1023 wraps to 0).
- HALT: stays in HALT until `reset`. IR holds the halt instruction. `instr_valid`=0.
- `start` is ignored outside IDLE. `exec_done`, `branch` and `jump` are ignored outside EXEC.
- Reset values: state=IDLE, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `halted`=0, `retired`=0.
- Reset in any state, including mid-EXEC, aborts the current instruction. No retirement is counted and no PC update occurs.

## Timing
- All state, PC, IR and counter updates occur on the `clk` rising edge. Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- `start` sampled at edge N: ADDR in cycle N+1, LATCH in N+2, `instr_valid`=1 from cycle N+3.
- `exec_done` in the first EXEC cycle gives a minimum of 3 cycles per instruction.
- A redirect takes effect at the retiring edge. `rom_addr` shows the new PC in the following ADDR cycle. There is no wrong-path fetch.
- The halt opcode is detected in LATCH. `halted` rises the cycle after LATCH and `instr_valid` never asserts for that instruction.

## Configuration
- `FETCH_SEQ_PERF_EN` defined:
  - `retired` port exists.
  - It increments by 1 on each EXEC edge with `exec_done`=1 and wraps from 16'hFFFF to 0.
  - It is cleared by `reset`.
- `FETCH_SEQ_PERF_EN` undefined: the `retired` port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset/sequential fetch: hold `reset` 2 cycles, then `start` for 1 cycle. ROM holds 10'h001,10'h002,10'h003 at addresses 0..2, and `exec_done` is tied to 1.
  - `instr` sequence is 001,002,003, with `instr_valid` at cycles 3,6,9 after `start`.
  - `pc` steps 0,1,2,3.
  - `retired`=3 (with the macro).
- Branch: at PC=5, retire with `branch`=1, `branch_addr`=100 -> the next ADDR shows `rom_addr`=100 and the instruction after that is fetched from 101.
- Jump priority: retire with `jump`=1, `jump_target`=500 and `branch`=1, `branch_addr`=100 -> PC=500.
- Stall: hold `exec_done`=0 for 10 cycles in EXEC -> `instr_valid` stays 1, `pc` and `instr` are stable, and `retired` does not change.
- Halt and wrap:
  - PC=1023 with a non-halt instruction, retired without redirect -> PC=0.
  - ROM[0]=10'b1111000000 -> `halted`=1, `instr_valid` never asserts, `pc` stays 0, and `start` is ignored.
- Reset mid-EXEC: assert `reset` together with `exec_done`=1 -> next cycle state=IDLE, `pc`=0, `instr`=0 and `retired` is unchanged by the retire (cleared to 0).
